// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N producer channels in, one registered
// output channel with its source tag. The master side drives stimulus and
// consumes the output; the slave side is the selector itself.
interface mux_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic [1:0]         mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered selector with valid/ready handshakes.
// Per cycle one producer is granted by explicit select, fixed priority
// (lowest index wins) or round-robin; the granted word and its channel
// index land in a single-entry output register. A new word is accepted
// whenever the register is empty or being drained in the same cycle.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_n_if.slave  bus
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);
  localparam logic [1:0]      MODE_SEL = 2'd0;
  localparam logic [1:0]      MODE_RR  = 2'd2;

  // Output register stage
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  src_p1;
  logic             vld_p1;

  // Round-robin search start pointer, always in 0..N-1
  logic [SELW-1:0]  rr;

  logic             load;
  logic [N-1:0]     gnt;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW:0]    cand;
  logic [SELW-1:0]  rr_next;

  // The register can take a word when empty or when its word leaves now.
  assign load = !vld_p1 || bus.out_ready;

  // Grant decision: pick at most one channel; nothing while held or in reset.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    cand     = '0;
    if (rst_n && load) begin
      case (bus.mode)
        MODE_SEL: begin
          // Only the addressed channel may win; an index >= N matches nothing.
          for (int i = 0; i < N; i++) begin
            if (!gnt_any && bus.sel == SELW'(i) && bus.in_valid[i]) begin
              gnt_any = 1'b1;
              gnt_idx = SELW'(i);
            end
          end
        end
        MODE_RR: begin
          // Walk N positions from rr, wrapping explicitly so non-power-of-two
          // N never visits an index beyond N-1.
          for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr} + (SELW + 1)'(k);
            if (cand >= N_EXT) begin
              cand = cand - N_EXT;
            end
            for (int i = 0; i < N; i++) begin
              if (!gnt_any && cand == (SELW + 1)'(i) && bus.in_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(i);
              end
            end
          end
        end
        default: begin
          // Fixed priority (modes 1 and 3): lowest valid index.
          for (int i = 0; i < N; i++) begin
            if (!gnt_any && bus.in_valid[i]) begin
              gnt_any = 1'b1;
              gnt_idx = SELW'(i);
            end
          end
        end
      endcase
      // Expand the winning index to the one-hot ready and steer its data.
      for (int i = 0; i < N; i++) begin
        if (gnt_any && gnt_idx == SELW'(i)) begin
          gnt[i]   = 1'b1;
          gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Pointer moves just past the winner, wrapping from N-1 back to 0.
  assign rr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // Stage p0 -> p1: capture the granted word, drain when nothing replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr      <= '0;
    end else begin
      if (gnt_any) begin
        data_p1 <= gnt_data;
        src_p1  <= gnt_idx;
        vld_p1  <= 1'b1;
      end else if (load) begin
        vld_p1  <= 1'b0;
      end
      if (bus.mode == MODE_RR && gnt_any) begin
        rr <= rr_next;
      end
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a 4-channel 32-bit instance driven from a vector
// table, plus a 3-channel 16-bit instance for the non-power-of-two wrap.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(32), .N(4), .SELW(2)) b4();
  mux_arb_n_if #(.WIDTH(16), .N(3), .SELW(2)) b3();

  mux_arb_n #(.WIDTH(32), .N(4), .SELW(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mux_arb_n #(.WIDTH(16), .N(3), .SELW(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;   // expected in_ready this cycle
    logic       ovld;  // expected out_valid after the edge
    logic [1:0] src;   // expected out_src after the edge
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t        sb4[$];
  exp_t        sb3[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last4 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge: drive, check ready, push expectation, cross the edge, compare.
  task automatic apply4(input vec_t r, input int idx, input logic ovr, input logic [31:0] ovr_data);
    logic [31:0] d[4];
    exp_t e;
    for (int i = 0; i < 4; i++) d[i] = ((i + 1) << 28) | 32'(idx);
    if (ovr) d[2] = ovr_data;
    b4.in_data   = {d[3], d[2], d[1], d[0]};
    b4.mode      = r.mode;
    b4.sel       = r.sel;
    b4.in_valid  = r.v;
    b4.out_ready = r.ordy;
    #1;
    chk($sformatf("v%0d in_ready", idx), 32'(b4.in_ready), 32'(r.rdy));
    for (int i = 0; i < 4; i++) begin
      if (r.rdy == 4'(1 << i)) begin
        e.data = d[i];
        e.src  = 2'(i);
        sb4.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(b4.out_valid), 32'(r.ovld));
    chk($sformatf("v%0d out_src", idx), 32'(b4.out_src), 32'(r.src));
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      chk($sformatf("v%0d out_data", idx), b4.out_data, e.data);
      chk($sformatf("v%0d sb_src", idx), 32'(b4.out_src), 32'(e.src));
      last4 = e.data;
    end else if (r.ovld) begin
      chk($sformatf("v%0d held_data", idx), b4.out_data, last4);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t tv[25];
    vec_t r;
    exp_t e;
    logic [15:0] d3[3];

    tv[0]  = '{2'd0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tv[1]  = '{2'd0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2};
    tv[2]  = '{2'd0, 2'd2, 4'b1011, 1'b0, 4'b0000, 1'b0, 2'd2};
    tv[3]  = '{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[4]  = '{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[5]  = '{2'd1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[6]  = '{2'd3, 2'd0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tv[7]  = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[8]  = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[9]  = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tv[10] = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[11] = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[12] = '{2'd2, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tv[13] = '{2'd2, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tv[14] = '{2'd2, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tv[15] = '{2'd2, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tv[16] = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[17] = '{2'd2, 2'd0, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd1};
    tv[18] = '{2'd0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tv[19] = '{2'd0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[20] = '{2'd2, 2'd3, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tv[21] = '{2'd2, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[22] = '{2'd2, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tv[23] = '{2'd2, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[24] = '{2'd1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};

    b4.mode = 2'd1; b4.sel = '0; b4.in_data = '1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    b3.mode = 2'd0; b3.sel = '0; b3.in_data = '0; b3.in_valid = '0;      b3.out_ready = 1'b1;

    // Reset state, with valid inputs present so an ungated ready would show.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst out_data", b4.out_data, 32'd0);
    chk("rst out_src", 32'(b4.out_src), 32'd0);
    chk("rst in_ready", 32'(b4.in_ready), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) apply4(tv[i], i, i == 0, 32'hDEADBEEF);

    // Reset mid-stream: load a word (moves rr to 2), then pull rst_n low.
    r = '{2'd2, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};
    apply4(r, 30, 1'b0, 32'd0);
    b4.mode = 2'd2; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst out_data", b4.out_data, 32'd0);
    chk("midrst out_src", 32'(b4.out_src), 32'd0);
    chk("midrst in_ready", 32'(b4.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst edge out_valid", 32'(b4.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb4.delete();
    r = '{2'd2, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    apply4(r, 31, 1'b0, 32'd0);
    b4.in_valid = '0;

    // Three channels, round-robin: sources go 0,1,2,0,1 and never 3.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) d3[i] = 16'hB000 + 16'(i * 16) + 16'(k);
      b3.in_data  = {d3[2], d3[1], d3[0]};
      b3.mode     = 2'd2;
      b3.in_valid = 3'b111;
      b3.out_ready = 1'b1;
      #1;
      chk($sformatf("n3 k%0d in_ready", k), 32'(b3.in_ready), 32'(1 << (k % 3)));
      e.data = 32'(d3[k % 3]);
      e.src  = 2'(k % 3);
      sb3.push_back(e);
      @(posedge clk);
      #1;
      e = sb3.pop_front();
      chk($sformatf("n3 k%0d out_src", k), 32'(b3.out_src), 32'(e.src));
      chk($sformatf("n3 k%0d out_data", k), 32'(b3.out_data), e.data);
      @(negedge clk);
    end

    // Explicit select beyond N-1 grants nothing; the word drains away.
    b3.mode = 2'd0; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
    #1;
    chk("n3 sel3 in_ready", 32'(b3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("n3 sel3 out_valid", 32'(b3.out_valid), 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
